// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge loader: bank-switch codes,
// loader FSM states and the file-extension to bank-switch mapping.
package cart_pkg;

  localparam logic [16:0] ROM_MAX     = 17'd32768;
  localparam int unsigned HOLD_CYCLES = 16;

  typedef enum logic [3:0] {
    BS_NONE = 4'd0,
    BS_F8   = 4'd1,
    BS_F6   = 4'd2,
    BS_FE   = 4'd3,
    BS_E0   = 4'd4,
    BS_3F   = 4'd5,
    BS_F4   = 4'd6,
    BS_P2   = 4'd7,
    BS_FA   = 4'd8,
    BS_CV   = 4'd9
  } bs_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Extension is three ASCII characters including the leading dot.
  function automatic bs_t ext_to_bs(input logic [23:0] ext);
    bs_t bs;
    case (ext)
      ".F8":   bs = BS_F8;
      ".F6":   bs = BS_F6;
      ".FE":   bs = BS_FE;
      ".E0":   bs = BS_E0;
      ".3F":   bs = BS_3F;
      ".F4":   bs = BS_F4;
      ".P2":   bs = BS_P2;
      ".FA":   bs = BS_FA;
      ".CV":   bs = BS_CV;
      default: bs = BS_NONE;
    endcase
    return bs;
  endfunction

endpackage

// File: rtl/cart_bs_detect.sv
// Watches bytes written into ROM for the F8/F6 bank-switch store idioms
// (STA/LDA abs to $1FF9 or $1FF6) and remembers which were seen.
module cart_bs_detect
  import cart_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       f8_seen,
  output logic       f6_seen
);

  logic [7:0] b1_q, b1_d, b0_q, b0_d;
  logic       f8_q, f8_d, f6_q, f6_d;
  logic       opcode_hit;

  // b1 holds the older byte, b0 the previous one; wr_data completes the triple.
  assign opcode_hit = (b1_q == 8'h8D || b1_q == 8'hAD) && (wr_data == 8'h1F);

  always_comb begin
    b1_d = b1_q;
    b0_d = b0_q;
    f8_d = f8_q;
    f6_d = f6_q;
    if (clear) begin
      b1_d = 8'h00;
      b0_d = 8'h00;
      f8_d = 1'b0;
      f6_d = 1'b0;
    end else if (wr_en) begin
      b1_d = b0_q;
      b0_d = wr_data;
      if (opcode_hit && b0_q == 8'hF9) f8_d = 1'b1;
      if (opcode_hit && b0_q == 8'hF6) f6_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      b1_q <= 8'h00;
      b0_q <= 8'h00;
      f8_q <= 1'b0;
      f6_q <= 1'b0;
    end else begin
      b1_q <= b1_d;
      b0_q <= b0_d;
      f8_q <= f8_d;
      f6_q <= f6_d;
    end
  end

  assign f8_seen = f8_q;
  assign f6_seen = f6_q;

endmodule

// File: rtl/cart_load_ctrl.sv
// Cartridge ROM download controller: streams HPS download bytes into ROM,
// holds the console in reset and reports size/bank-switch scheme.
// Define CART_BS_DETECT_EN to auto-detect F8/F6/F4 when the extension is unknown.
module cart_load_ctrl
  import cart_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [23:0] file_ext,
  input  logic [1:0]  sc_mode,
  input  logic        sc_tag,
  output logic        rom_we,
  output logic [14:0] rom_waddr,
  output logic [7:0]  rom_wdata,
  output logic        hold_reset,
  output logic [3:0]  force_bs,
  output logic        sc,
  output logic [16:0] rom_size,
  output logic        overflow,
  output logic        load_done
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic        dl_q;
  logic        rom_we_q, rom_we_d;
  logic [14:0] rom_waddr_q, rom_waddr_d;
  logic [7:0]  rom_wdata_q, rom_wdata_d;
  logic        hold_reset_q, hold_reset_d;
  bs_t         force_bs_q, force_bs_d;
  logic        sc_q, sc_d;
  logic [16:0] cnt_q, cnt_d;
  logic [16:0] rom_size_q, rom_size_d;
  logic        overflow_q, overflow_d;
  logic        load_done_q, load_done_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;

  logic        dl_rise, dl_fall, in_range, load_wr, load_start;
  logic [17:0] addr_plus1;

  assign dl_rise    = ioctl_download & ~dl_q;
  assign dl_fall    = ~ioctl_download & dl_q;
  assign in_range   = ioctl_addr < ROM_MAX;
  assign load_wr    = (state_q == LOAD) && ioctl_wr && in_range;
  assign addr_plus1 = {1'b0, ioctl_addr} + 18'd1;

`ifdef CART_BS_DETECT_EN
  logic f8_seen, f6_seen;
  bs_t  detect_bs;

  cart_bs_detect u_detect (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (load_start),
    .wr_en   (load_wr),
    .wr_data (ioctl_dout),
    .f8_seen (f8_seen),
    .f6_seen (f6_seen)
  );

  always_comb begin
    detect_bs = BS_NONE;
    if (cnt_q == (ROM_MAX >> 2) && f8_seen)      detect_bs = BS_F8;
    else if (cnt_q == (ROM_MAX >> 1) && f6_seen) detect_bs = BS_F6;
    else if (cnt_q == ROM_MAX)                   detect_bs = BS_F4;
  end
`endif

  always_comb begin
    state_d     = state_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    force_bs_d  = force_bs_q;
    sc_d        = sc_q;
    cnt_d       = cnt_q;
    rom_size_d  = rom_size_q;
    overflow_d  = overflow_q;
    load_done_d = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    load_start  = 1'b0;

    case (state_q)
      IDLE: if (dl_rise) load_start = 1'b1;
      // A strobe in the same cycle as the falling edge is still committed.
      LOAD: begin
        if (ioctl_wr) begin
          rom_waddr_d = ioctl_addr[14:0];
          rom_wdata_d = ioctl_dout;
          rom_we_d    = in_range;
          if (!in_range) overflow_d = 1'b1;
          if (addr_plus1 > {1'b0, cnt_q})
            cnt_d = addr_plus1[17] ? 17'h1FFFF : addr_plus1[16:0];
        end
        if (dl_fall) state_d = FINISH;
      end
      FINISH: begin
        rom_size_d  = cnt_q;
        load_done_d = 1'b1;
        hold_cnt_d  = 4'd0;
        state_d     = HOLD;
`ifdef CART_BS_DETECT_EN
        if (force_bs_q == BS_NONE) force_bs_d = detect_bs;
`endif
      end
      HOLD: begin
        if (dl_rise)                    load_start = 1'b1;
        else if (hold_cnt_q == HOLD_LAST) state_d  = IDLE;
        else                            hold_cnt_d = hold_cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (load_start) begin
      state_d    = LOAD;
      cnt_d      = 17'd0;
      overflow_d = 1'b0;
      force_bs_d = ext_to_bs(file_ext);
      case (sc_mode)
        2'd0:    sc_d = sc_tag;
        2'd1:    sc_d = 1'b0;
        default: sc_d = 1'b1;
      endcase
    end

    hold_reset_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      rom_we_q     <= 1'b0;
      rom_waddr_q  <= 15'd0;
      rom_wdata_q  <= 8'd0;
      hold_reset_q <= 1'b0;
      force_bs_q   <= BS_NONE;
      sc_q         <= 1'b0;
      cnt_q        <= 17'd0;
      rom_size_q   <= 17'd0;
      overflow_q   <= 1'b0;
      load_done_q  <= 1'b0;
      hold_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      dl_q         <= ioctl_download;
      rom_we_q     <= rom_we_d;
      rom_waddr_q  <= rom_waddr_d;
      rom_wdata_q  <= rom_wdata_d;
      hold_reset_q <= hold_reset_d;
      force_bs_q   <= force_bs_d;
      sc_q         <= sc_d;
      cnt_q        <= cnt_d;
      rom_size_q   <= rom_size_d;
      overflow_q   <= overflow_d;
      load_done_q  <= load_done_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign hold_reset = hold_reset_q;
  assign force_bs   = force_bs_q;
  assign sc         = sc_q;
  assign rom_size   = rom_size_q;
  assign overflow   = overflow_q;
  assign load_done  = load_done_q;

endmodule
